// File: rtl/pipe_ifid_buf.sv
// ---------------------------------------------------------------------------
// pipe_ifid_buf
//   IF/ID stage buffer: a 2-entry FIFO (skid buffer) between instruction
//   fetch and decode. Fetched {pc4, inst} pairs are queued and the oldest
//   entry is presented to decode under a valid/ready handshake. Fetched
//   instructions flagged with f_flush are squashed (never stored) and
//   counted in a saturating debug counter. A kill from a later stage
//   discards all buffered work.
//
// Ports
//   clock       in   single clock, rising edge
//   reset       in   synchronous active-high reset
//   if_valid    in   fetch presents an instruction
//   if_ready    out  buffer can accept (not full, not in reset)
//   pc4         in   PC+4 of fetched instruction
//   inst        in   fetched instruction word
//   f_flush     in   fetched instruction is to be squashed
//   kill        in   redirect: drop buffered and incoming instructions
//   id_valid    out  head entry valid
//   id_ready    in   decode accepts the head this cycle
//   dpc4        out  head PC+4 (0 when empty)
//   dinst       out  head instruction (NOP/0 when empty)
//   count       out  occupancy 0..2
//   squash_cnt  out  saturating count of squashed instructions
// ---------------------------------------------------------------------------
module pipe_ifid_buf #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      pc4,
    input  logic [31:0]      inst,
    input  logic             f_flush,
    input  logic             kill,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [31:0]      dpc4,
    output logic [31:0]      dinst,
    output logic [1:0]       count,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [1:0]       count_q, count_d;
    logic             wp_q, wp_d;
    logic             rp_q, rp_d;
    logic [CNT_W-1:0] squash_q, squash_d;

    logic [31:0] pc_q   [DEPTH];
    logic [31:0] inst_q [DEPTH];

    logic accept;
    logic push;
    logic squash;
    logic pop;
    logic not_empty;

    // Full blocks acceptance even when a pop happens in the same cycle:
    // there is no bypass path at full.
    assign if_ready  = (count_q != 2'd2) && !reset;
    assign not_empty = (count_q != 2'd0) && !reset;
    assign id_valid  = not_empty;

    assign accept = if_valid && if_ready && !kill;
    assign push   = accept && !f_flush;
    assign squash = accept && f_flush;
    assign pop    = id_valid && id_ready && !kill;

    // Head is a combinational select of the read pointer, forced to zero
    // (a NOP) when nothing is buffered.
    assign dpc4       = not_empty ? pc_q[rp_q]   : 32'h0;
    assign dinst      = not_empty ? inst_q[rp_q] : 32'h0;
    assign count      = count_q;
    assign squash_cnt = squash_q;

    always_comb begin
        count_d  = count_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        squash_d = squash_q;
        if (kill) begin
            count_d = 2'd0;
            wp_d    = 1'b0;
            rp_d    = 1'b0;
        end else begin
            if (push) begin
                wp_d = ~wp_q;
            end
            if (pop) begin
                rp_d = ~rp_q;
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
            if (squash && (squash_q != {CNT_W{1'b1}})) begin
                squash_d = squash_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= 2'd0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            squash_q <= '0;
        end else begin
            count_q  <= count_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            squash_q <= squash_d;
        end
    end

    // One register pair per entry; only the entry under the write pointer
    // is loaded on a push.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic IDX = 1'(gi);
            always_ff @(posedge clock) begin
                if (reset) begin
                    pc_q[gi]   <= 32'h0;
                    inst_q[gi] <= 32'h0;
                end else if (push && (wp_q == IDX)) begin
                    pc_q[gi]   <= pc4;
                    inst_q[gi] <= inst;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_ifid_buf.sv
module tb_pipe_ifid_buf;

    logic        clock;
    logic        reset;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        f_flush;
    logic        kill;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] dpc4;
    logic [31:0] dinst;
    logic [1:0]  count;
    logic [15:0] squash_cnt;

    int total;
    int bad;

    pipe_ifid_buf #(.DEPTH(2), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .pc4        (pc4),
        .inst       (inst),
        .f_flush    (f_flush),
        .kill       (kill),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .dpc4       (dpc4),
        .dinst      (dinst),
        .count      (count),
        .squash_cnt (squash_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        if_valid = 1'b1;
        pc4      = 32'h0000_0100;
        inst     = 32'h1234_5678;
        f_flush  = 1'b0;
        kill     = 1'b0;
        id_ready = 1'b1;

        // Reset held two cycles with fetch offering.
        tick();
        tick();
        chk("rst_if_ready", {31'h0, if_ready}, 32'h0);
        chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_dinst", dinst, 32'h0);
        chk("rst_dpc4", dpc4, 32'h0);
        chk("rst_count", {30'h0, count}, 32'h0);
        chk("rst_squash", {16'h0, squash_cnt}, 32'h0);
        reset    = 1'b0;
        if_valid = 1'b0;
        #1;
        chk("post_rst_if_ready", {31'h0, if_ready}, 32'h1);

        // Streaming with decode always ready.
        if_valid = 1'b1; pc4 = 32'h4; inst = 32'h2008_0005;
        tick();
        chk("stream1_dinst", dinst, 32'h2008_0005);
        chk("stream1_dpc4", dpc4, 32'h4);
        chk("stream1_count", {30'h0, count}, 32'h1);
        pc4 = 32'h8; inst = 32'h2009_0003;
        tick();
        chk("stream2_dinst", dinst, 32'h2009_0003);
        chk("stream2_dpc4", dpc4, 32'h8);
        chk("stream2_count", {30'h0, count}, 32'h1);
        if_valid = 1'b0;
        tick();
        chk("stream_drain_count", {30'h0, count}, 32'h0);
        chk("stream_drain_valid", {31'h0, id_valid}, 32'h0);
        chk("stream_drain_dinst", dinst, 32'h0);

        // Stall to full, then release across the pointer wrap.
        id_ready = 1'b0;
        if_valid = 1'b1; pc4 = 32'h10; inst = 32'hA000_0001;
        tick();
        pc4 = 32'h14; inst = 32'hB000_0002;
        tick();
        chk("full_count", {30'h0, count}, 32'h2);
        chk("full_if_ready", {31'h0, if_ready}, 32'h0);
        chk("full_head_A", dinst, 32'hA000_0001);
        pc4 = 32'h18; inst = 32'hC000_0003;
        tick();
        chk("full_C_rejected_count", {30'h0, count}, 32'h2);
        chk("stall_hold_dinst", dinst, 32'hA000_0001);
        chk("stall_hold_dpc4", dpc4, 32'h10);
        id_ready = 1'b1;
        #1;
        chk("full_pop_if_ready", {31'h0, if_ready}, 32'h0);
        tick();
        chk("release_B", dinst, 32'hB000_0002);
        chk("release_B_count", {30'h0, count}, 32'h1);
        tick();
        chk("release_C", dinst, 32'hC000_0003);
        chk("release_C_pc", dpc4, 32'h18);
        chk("release_C_count", {30'h0, count}, 32'h1);
        if_valid = 1'b0;
        tick();
        chk("release_empty", {30'h0, count}, 32'h0);

        // Flush squash.
        if_valid = 1'b1; f_flush = 1'b1; pc4 = 32'h1C; inst = 32'h8C01_0000;
        tick();
        chk("squash_count", {30'h0, count}, 32'h0);
        chk("squash_cnt1", {16'h0, squash_cnt}, 32'h1);
        chk("squash_dinst", dinst, 32'h0);
        f_flush = 1'b0; if_valid = 1'b0;

        // Kill with buffer full and everything else active.
        id_ready = 1'b0;
        if_valid = 1'b1; pc4 = 32'h20; inst = 32'hD000_0004;
        tick();
        pc4 = 32'h24; inst = 32'hE000_0005;
        tick();
        chk("prekill_count", {30'h0, count}, 32'h2);
        kill = 1'b1; id_ready = 1'b1; pc4 = 32'h28; inst = 32'hF000_0006;
        tick();
        chk("kill_count", {30'h0, count}, 32'h0);
        chk("kill_id_valid", {31'h0, id_valid}, 32'h0);
        chk("kill_dinst", dinst, 32'h0);
        chk("kill_squash", {16'h0, squash_cnt}, 32'h1);
        // Kill while a flagged instruction is offered: no squash counted.
        f_flush = 1'b1;
        tick();
        chk("kill_flush_squash", {16'h0, squash_cnt}, 32'h1);
        chk("kill_flush_count", {30'h0, count}, 32'h0);
        kill = 1'b0; f_flush = 1'b0;

        // Push after kill appears normally.
        id_ready = 1'b0; pc4 = 32'h30; inst = 32'h6000_0006;
        tick();
        chk("postkill_dinst", dinst, 32'h6000_0006);
        chk("postkill_count", {30'h0, count}, 32'h1);

        // Simultaneous push and pop at count 1.
        id_ready = 1'b1; pc4 = 32'h34; inst = 32'h7000_0007;
        tick();
        chk("pushpop_count", {30'h0, count}, 32'h1);
        chk("pushpop_dinst", dinst, 32'h7000_0007);
        chk("pushpop_dpc4", dpc4, 32'h34);
        if_valid = 1'b0;
        tick();
        chk("pushpop_drain", {30'h0, count}, 32'h0);

        // Drive the squash counter to saturation.
        if_valid = 1'b1; f_flush = 1'b1; inst = 32'h8C01_0000;
        repeat (65534) @(posedge clock);
        #1;
        chk("squash_sat", {16'h0, squash_cnt}, 32'h0000_FFFF);
        tick();
        chk("squash_sat_hold", {16'h0, squash_cnt}, 32'h0000_FFFF);
        chk("squash_sat_count", {30'h0, count}, 32'h0);
        f_flush = 1'b0;

        // Reset in the middle of activity.
        id_ready = 1'b0; pc4 = 32'h40; inst = 32'h9000_0009;
        tick();
        chk("midrst_pre_count", {30'h0, count}, 32'h1);
        reset = 1'b1; kill = 1'b1;
        tick();
        chk("midrst_count", {30'h0, count}, 32'h0);
        chk("midrst_squash", {16'h0, squash_cnt}, 32'h0);
        chk("midrst_if_ready", {31'h0, if_ready}, 32'h0);
        chk("midrst_dinst", dinst, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
